// File: rtl/quad_encoder_pkg.sv
// Shared constants and decode helpers for the quadrature encoder counter.
package quad_encoder_pkg;

  // Resolution select encodings; the unused code 2'd3 behaves as x1.
  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // Encoder states as {a, b}; the up sequence is 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_DOWN    = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } move_e;

  // Classify one state change of the filtered A/B pair.
  function automatic move_e classify_move(input logic [1:0] prev_s, input logic [1:0] cur_s);
    move_e res;
    case ({prev_s, cur_s})
      {ST_00, ST_01}, {ST_01, ST_11}, {ST_11, ST_10}, {ST_10, ST_00}: res = MOVE_UP;
      {ST_01, ST_00}, {ST_11, ST_01}, {ST_10, ST_11}, {ST_00, ST_10}: res = MOVE_DOWN;
      {ST_00, ST_11}, {ST_11, ST_00}, {ST_01, ST_10}, {ST_10, ST_01}: res = MOVE_ILLEGAL;
      default: res = MOVE_NONE;
    endcase
    return res;
  endfunction

  // Decide whether a legal transition is counted at the selected resolution.
  // x2 counts any change of A; x1 counts only a rising A (01->11 up, 00->10 down).
  function automatic logic move_counts(input logic [1:0] mode_s, input logic [1:0] prev_s,
                                       input logic [1:0] cur_s);
    logic res;
    case (mode_s)
      MODE_X4: res = 1'b1;
      MODE_X2: res = prev_s[1] ^ cur_s[1];
      MODE_X1: res = ~prev_s[1] & cur_s[1];
      default: res = ~prev_s[1] & cur_s[1];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_filter.sv
// One encoder channel: multi-flop synchroniser followed by a stable-count
// glitch filter. Idle level is 1 to match a pulled-up encoder pin.
module quad_encoder_filter
  import quad_encoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];
  assign dout     = filt_q;

  // Next-state logic: shift the synchroniser and run the stability counter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (synced_s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        // Input has differed long enough: accept the new level.
        filt_d = synced_s;
        cnt_d  = {CW{1'b0}};
      end else begin
        filt_d = filt_q;
        cnt_d  = cnt_q + CW'(1);
      end
    end else begin
      // Any return to the filtered level restarts the stability window.
      filt_d = filt_q;
      cnt_d  = {CW{1'b0}};
    end
  end

  // State registers, cleared to the idle-high level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      filt_q <= 1'b1;
      cnt_q  <= {CW{1'b0}};
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder and position counter: filtered A/B channels feed a
// state-change decoder with x1/x2/x4 resolution, illegal-jump detection and
// a wrap/saturate counter with synchronous clear and load.
module quad_encoder_counter
  import quad_encoder_pkg::*;
#(
  parameter int               WIDTH         = 16,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter int               SATURATE      = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             error
);

  localparam logic [WIDTH-1:0] VAL_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);

  logic             a_f_s, b_f_s;
  logic [1:0]       s_s;
  move_e            move_s;
  logic             count_en_s;
  logic             up_s;

  logic [1:0]       prev_q, prev_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             error_q, error_d;

  quad_encoder_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_a (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (a),
    .dout   (a_f_s)
  );

  quad_encoder_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filt_b (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (b),
    .dout   (b_f_s)
  );

  assign s_s   = {a_f_s, b_f_s};
  assign value = value_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign error = error_q;

  // Decode the filtered state change against the registered mode.
  always_comb begin
    move_s     = classify_move(prev_q, s_s);
    up_s       = (move_s == MOVE_UP);
    count_en_s = 1'b0;
    if ((move_s == MOVE_UP) || (move_s == MOVE_DOWN)) begin
      count_en_s = move_counts(mode_q, prev_q, s_s);
    end else begin
      count_en_s = 1'b0;
    end
  end

  // Counter next state: clear beats load beats a decoded step.
  always_comb begin
    prev_d  = s_s;
    mode_d  = mode;
    value_d = value_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    error_d = (move_s == MOVE_ILLEGAL);
    if (clear) begin
      value_d = RESET_VALUE;
    end else if (load) begin
      value_d = load_value;
    end else if (count_en_s) begin
      step_d = 1'b1;
      dir_d  = up_s;
      if (up_s) begin
        if (value_q == VAL_MAX) begin
          value_d = (SATURATE != 0) ? value_q : VAL_ZERO;
        end else begin
          value_d = value_q + VAL_ONE;
        end
      end else begin
        if (value_q == VAL_ZERO) begin
          value_d = (SATURATE != 0) ? value_q : VAL_MAX;
        end else begin
          value_d = value_q - VAL_ONE;
        end
      end
    end else begin
      value_d = value_q;
    end
  end

  // Decoder history, mode and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= ST_11;
      mode_q  <= MODE_X1;
      value_q <= RESET_VALUE;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
      error_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      error_q <= error_d;
    end
  end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Parametrised quadrature decoder and position counter for PMOD-style rotary encoders and incremental shaft encoders. It succeeds the single-edge A/B counter with:
- input synchronisers and a per-channel glitch filter;
- selectable x1/x2/x4 resolution;
- illegal-transition detection;
- wrap or saturate arithmetic;
- synchronous clear and load.
It sits between raw encoder pins and user logic such as a display driver or setpoint register.

Parameters:
WIDTH, 16, counter width in bits (unsigned).
SYNC_STAGES, 2, flip-flop synchroniser depth per input; minimum 2.
FILTER_CYCLES, 4, consecutive stable cycles required before a filtered channel changes; minimum 1.
SATURATE, 0, 0 = wrap modulo 2^WIDTH, 1 = clamp at 0 and 2^WIDTH-1.
RESET_VALUE, 0, value loaded into the counter on reset and on clear.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
a  input  1  encoder channel A, asynchronous to clk
b  input  1  encoder channel B, asynchronous to clk
mode  input  2  0 = x1, 1 = x2, 2 = x4, 3 = x1
clear  input  1  synchronous; sets value to RESET_VALUE
load  input  1  synchronous; sets value to load_value
load_value  input  WIDTH  value written on load
value  output  WIDTH  current position count (registered)
step  output  1  one-cycle pulse on each counted step
dir  output  1  direction of the last counted step: 1 = up, 0 = down
error  output  1  one-cycle pulse on an illegal A/B transition

Behaviour:
- The design has one clock, clk. Reset is asynchronous, active-low (reset_n); all flops are cleared asynchronously.
- Reset values:
  - value = RESET_VALUE; step = 0; dir = 1; error = 0.
  - Synchroniser and filter flops = 1, matching an idle pulled-up encoder.
  - Previous-state register = 2'b11.
  - Filter counters = 0.
- Synchroniser: a and b each pass through SYNC_STAGES flops.
- Filter, per channel: a counter runs while the synced input differs from the filtered output. The counter resets to 0 whenever the synced input equals the filtered output. When the counter reaches FILTER_CYCLES-1 while inputs still differ, the filtered output takes the new value and the counter resets. Pulses shorter than FILTER_CYCLES cycles never reach the decoder.
- Decoder: s = {a_f, b_f}; prev = s of the previous cycle. The up sequence is 00 -> 01 -> 11 -> 10 -> 00; the reverse order is down.
  - x4: every legal transition counts.
  - x2: only transitions that change a_f count. Up: 01->11, 10->00. Down: 00->10, 11->01.
  - x1: only rising a_f counts. Up: 01->11. Down: 00->10.
  - s == prev: no action.
  - Both bits change (00<->11, 01<->10): error pulses next cycle, no count, and dir is unchanged.
- Counter update is registered; priority is clear > load > count.
  - clear or load in the same cycle as a step: the step is dropped and step does not pulse.
- Arithmetic:
  - SATURATE = 0: up at 2^WIDTH-1 wraps to 0, and down at 0 wraps to 2^WIDTH-1.
  - SATURATE = 1: the value holds at the limit. step still pulses and dir still updates.
- step and dir update in the same cycle as value.
- Latency from a pin edge to the value change is SYNC_STAGES + FILTER_CYCLES + 1 cycles.
- A mode change takes effect for transitions decoded in the following cycle. prev is not reset on a mode change.
- Reset assertion mid-rotation returns every register to its reset value. The first decoded transition after reset is taken relative to prev = 11.

Decomposition:
- Package quad_encoder_pkg holds:
  - mode constants MODE_X1 = 2'd0, MODE_X2 = 2'd1, MODE_X4 = 2'd2;
  - state constants for 00, 01, 11 and 10.
- Sub-module quad_encoder_filter: a synchroniser plus stable-count filter for one channel, parametrised by SYNC_STAGES and FILTER_CYCLES. It is instantiated twice.
- Decoder and counter live in the top level.

Test Plan:
- Reset then idle: with a = b = 1 held, value = 0, step = 0 and error = 0 for 100 cycles.
- x4 up: mode = 2. One full up cycle, each state held 10 cycles, gives value = 4 and 4 step pulses with dir = 1. The reverse cycle returns value = 0 with dir = 0.
- x1 and x2: the same single up cycle gives value = 1 with mode = 0 and value = 2 with mode = 1.
- Glitch and illegal transition, with FILTER_CYCLES = 4:
  - a 3-cycle low pulse on a gives no value change;
  - a jump from 01 to 10 with both inputs stable gives one error pulse and value unchanged.
- Boundaries, WIDTH = 4:
  - SATURATE = 0: load 15, one x4 up step gives value = 0; one down step from 0 gives 15.
  - SATURATE = 1: value holds at 15 and at 0, and step still pulses.
- Priority: load = 1 with load_value = 0x1234 in the same cycle as a counted step gives value = 0x1234 and no step pulse. clear together with load gives value = RESET_VALUE.
